// File: rtl/sdp_wdma_dat_pack.sv
`default_nettype none
// ==== sdp_wdma_dat_pack : SDP write-DMA packer, header + masked data beats per command ====
// ==== Rev 1.0                                                                           ====
module sdp_wdma_dat_pack #(
    parameter int ATOM_W      = 256,
    parameter int DMA_ATOMS   = 2,
    parameter int DFIFO_DEPTH = 8,
    parameter int ADDR_W      = 64,
    parameter int SIZE_W      = 13,
    localparam int DW         = ATOM_W * DMA_ATOMS,
    localparam int PD_W       = DW + DMA_ATOMS + 1
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
    input  logic                       cmd_vld,
    output logic                       cmd_rdy,
    input  logic [ADDR_W+SIZE_W:0]     cmd_pd,
    input  logic                       sdp_dp2wdma_valid,
    output logic                       sdp_dp2wdma_ready,
    input  logic [ATOM_W-1:0]          sdp_dp2wdma_pd,
    output logic                       dma_wr_req_vld,
    input  logic                       dma_wr_req_rdy,
    output logic [PD_W-1:0]            dma_wr_req_pd,
    input  logic                       op_load,
    input  logic                       reg2dp_interrupt_ptr,
    output logic                       dp2reg_done,
    output logic                       intr_req_pvld,
    output logic                       intr_req_ptr,
    output logic [31:0]                dp2reg_status_beat_cnt
);

    localparam int PTR_W = $clog2(DFIFO_DEPTH);
    localparam int CNT_W = $clog2(DFIFO_DEPTH + 1);
    localparam int REM_W = SIZE_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ATOM_W-1:0]    mem_q [DFIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [REM_W-1:0]     rem_q, rem_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;
    logic                 ptr_q, ptr_d;
    logic [31:0]          beat_cnt_q, beat_cnt_d;

    logic                 push;
    logic                 pop;
    logic [CNT_W-1:0]     pop_n;
    logic [SIZE_W-1:0]    beats_m1;
    logic [PTR_W-1:0]     rd_idx;
    logic [PD_W-1:0]      pd_hdr;
    logic [PD_W-1:0]      pd_data;

    assign sdp_dp2wdma_ready = (count_q != CNT_W'(DFIFO_DEPTH));
    assign push              = sdp_dp2wdma_valid && sdp_dp2wdma_ready;
    assign pop_n             = (rem_q >= REM_W'(DMA_ATOMS)) ? CNT_W'(DMA_ATOMS) : CNT_W'(rem_q);
    // In HDR rem_q still holds the full atom count, so this is ceil(atoms/DMA_ATOMS)-1.
    assign beats_m1          = SIZE_W'((rem_q - REM_W'(1)) / REM_W'(DMA_ATOMS));

    always_comb begin
        pd_hdr                     = '0;
        pd_hdr[ADDR_W-1:0]         = addr_q;
        pd_hdr[ADDR_W +: SIZE_W]   = beats_m1;
        pd_data                    = '0;
        pd_data[PD_W-1]            = 1'b1;
        rd_idx                     = '0;
        for (int k = 0; k < DMA_ATOMS; k++) begin
            rd_idx = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < pop_n) begin
                pd_data[k*ATOM_W +: ATOM_W] = mem_q[rd_idx];
                pd_data[DW + k]             = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rem_d          = rem_q;
        last_d         = last_q;
        done_d         = 1'b0;
        beat_cnt_d     = beat_cnt_q;
        ptr_d          = ptr_q;
        cmd_rdy        = 1'b0;
        dma_wr_req_vld = 1'b0;
        dma_wr_req_pd  = '0;
        pop            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_vld) begin
                    addr_d  = cmd_pd[ADDR_W-1:0];
                    rem_d   = REM_W'(cmd_pd[ADDR_W +: SIZE_W]) + REM_W'(1);
                    last_d  = cmd_pd[ADDR_W+SIZE_W];
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                dma_wr_req_vld = 1'b1;
                dma_wr_req_pd  = pd_hdr;
                if (dma_wr_req_rdy) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (count_q >= pop_n) begin
                    dma_wr_req_vld = 1'b1;
                    dma_wr_req_pd  = pd_data;
                    if (dma_wr_req_rdy) begin
                        pop        = 1'b1;
                        rem_d      = rem_q - REM_W'(pop_n);
                        beat_cnt_d = beat_cnt_q + 32'd1;
                        if (rem_q == REM_W'(pop_n)) begin
                            done_d  = last_q;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (op_load) begin
            beat_cnt_d = '0;
            ptr_d      = reg2dp_interrupt_ptr;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(pop_n) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - (pop ? pop_n : CNT_W'(0));
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            ptr_q      <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            last_q     <= last_d;
            done_q     <= done_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sdp_dp2wdma_pd;
        end
    end

    assign dp2reg_done            = done_q;
    assign intr_req_pvld          = done_q;
    assign intr_req_ptr           = ptr_q;
    assign dp2reg_status_beat_cnt = beat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sdp_wdma_dat_pack.sv
`default_nettype none
// ==== tb_sdp_wdma_dat_pack : directed + random checks of header/data packing ====
// ==== Rev 1.0                                                                 ====
module tb_sdp_wdma_dat_pack;

    localparam int ATOM_W = 64;
    localparam int DA     = 2;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 64;
    localparam int SIZE_W = 13;
    localparam int DW     = ATOM_W * DA;
    localparam int PD_W   = DW + DA + 1;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   cmd_vld = 1'b0;
    logic                   cmd_rdy;
    logic [ADDR_W+SIZE_W:0] cmd_pd = '0;
    logic                   sdp_valid = 1'b0;
    logic                   sdp_ready;
    logic [ATOM_W-1:0]      sdp_pd = '0;
    logic                   dma_vld;
    logic                   dma_rdy = 1'b0;
    logic [PD_W-1:0]        dma_pd;
    logic                   op_load = 1'b0;
    logic                   ptr_in = 1'b0;
    logic                   done;
    logic                   pvld;
    logic                   intr_ptr;
    logic [31:0]            beat_cnt;

    int                     checks = 0;
    int                     errors = 0;
    logic [ATOM_W-1:0]      atom_q[$];
    int                     exp_beats = 0;
    bit                     exp_ptr = 1'b0;

    sdp_wdma_dat_pack #(
        .ATOM_W(ATOM_W), .DMA_ATOMS(DA), .DFIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)
    ) dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rstn        (rstn),
        .cmd_vld                (cmd_vld),
        .cmd_rdy                (cmd_rdy),
        .cmd_pd                 (cmd_pd),
        .sdp_dp2wdma_valid      (sdp_valid),
        .sdp_dp2wdma_ready      (sdp_ready),
        .sdp_dp2wdma_pd         (sdp_pd),
        .dma_wr_req_vld         (dma_vld),
        .dma_wr_req_rdy         (dma_rdy),
        .dma_wr_req_pd          (dma_pd),
        .op_load                (op_load),
        .reg2dp_interrupt_ptr   (ptr_in),
        .dp2reg_done            (done),
        .intr_req_pvld          (pvld),
        .intr_req_ptr           (intr_ptr),
        .dp2reg_status_beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [PD_W-1:0] obs, input logic [PD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_rdy"}, cmd_rdy, 1);
        chk({tag, "_sdp_ready"}, sdp_ready, 1);
        chk({tag, "_dma_vld"}, dma_vld, 0);
        chk({tag, "_dma_pd"}, dma_pd, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pvld"}, pvld, 0);
        chk({tag, "_ptr"}, intr_ptr, 0);
        chk({tag, "_beat_cnt"}, beat_cnt, 0);
    endtask

    task automatic push_atoms(input int cnt);
        logic [ATOM_W-1:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = {$urandom, $urandom};
            sdp_valid = 1'b1;
            sdp_pd    = a;
            chk("atom_ready", sdp_ready, 1);
            tick();
            atom_q.push_back(a);
        end
        sdp_valid = 1'b0;
    endtask

    // Expected packets come straight from the packet rules: header carries
    // ceil(atoms/DA)-1, each data beat takes the next min(DA, left) atoms in order.
    task automatic run_cmd(input int cnt_m1, input logic [ADDR_W-1:0] addr, input bit last, input bit bp);
        int               left;
        int               n;
        int               stall;
        int               beats_m1;
        logic [PD_W-1:0]  exp;
        beats_m1 = ((cnt_m1 + 1) + DA - 1) / DA - 1;
        exp = '0;
        exp[ADDR_W-1:0]       = addr;
        exp[ADDR_W +: SIZE_W] = SIZE_W'(beats_m1);
        chk("cmd_rdy_idle", cmd_rdy, 1);
        cmd_pd  = {last, SIZE_W'(cnt_m1), addr};
        cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
        cmd_pd  = '0;
        chk("cmd_rdy_busy", cmd_rdy, 0);
        chk("hdr_vld", dma_vld, 1);
        chk("hdr_pd", dma_pd, exp);
        chk("done_quiet", done, 0);
        stall = bp ? int'($urandom_range(1, 3)) : 0;
        for (int s = 0; s < stall; s++) begin
            dma_rdy = 1'b0;
            tick();
            chk("hdr_hold_vld", dma_vld, 1);
            chk("hdr_hold_pd", dma_pd, exp);
        end
        dma_rdy = 1'b1;
        tick();
        left = cnt_m1 + 1;
        while (left > 0) begin
            n = (left < DA) ? left : DA;
            exp = '0;
            exp[PD_W-1] = 1'b1;
            for (int k = 0; k < n; k++) begin
                exp[k*ATOM_W +: ATOM_W] = atom_q[k];
                exp[DW + k]             = 1'b1;
            end
            chk("beat_vld", dma_vld, 1);
            chk("beat_pd", dma_pd, exp);
            stall = bp ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s < stall; s++) begin
                dma_rdy = 1'b0;
                tick();
                chk("beat_hold_vld", dma_vld, 1);
                chk("beat_hold_pd", dma_pd, exp);
            end
            dma_rdy = 1'b1;
            tick();
            for (int k = 0; k < n; k++) void'(atom_q.pop_front());
            left -= n;
            exp_beats++;
        end
        dma_rdy = 1'b0;
        chk("done_pulse", done, last);
        chk("intr_pvld", pvld, last);
        if (last) chk("intr_ptr", intr_ptr, exp_ptr);
        chk("beat_cnt", beat_cnt, exp_beats);
        chk("cmd_rdy_after", cmd_rdy, 1);
    endtask

    initial begin
        // Power-on reset
        tick();
        tick();
        check_reset("reset");
        rstn = 1'b1;
        tick();

        // Layer start with pointer 1, then the input changes
        op_load = 1'b1;
        ptr_in  = 1'b1;
        tick();
        op_load = 1'b0;
        ptr_in  = 1'b0;
        exp_ptr = 1'b1;
        exp_beats = 0;
        tick();
        chk("ptr_latched", intr_ptr, 1);
        chk("beat_cnt_cleared", beat_cnt, 0);

        // Even command: 4 atoms, two full beats
        push_atoms(4);
        run_cmd(3, 64'h1000, 1'b1, 1'b0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("pvld_one_cycle", pvld, 0);

        // Odd command: partial final beat
        push_atoms(3);
        run_cmd(2, 64'h2000, 1'b1, 1'b1);

        // FIFO full while DMA is idle
        push_atoms(DEPTH);
        chk("fifo_full", sdp_ready, 0);
        sdp_valid = 1'b1;
        sdp_pd    = {$urandom, $urandom};
        tick();
        chk("fifo_full_hold", sdp_ready, 0);
        sdp_valid = 1'b0;
        run_cmd(DEPTH - 1, 64'h3000, 1'b0, 1'b1);
        chk("fifo_drained", sdp_ready, 1);

        // Two back-to-back commands, last_cmd 0 then 1
        push_atoms(7);
        run_cmd(3, 64'h4000, 1'b0, 1'b0);
        run_cmd(2, 64'h5000, 1'b1, 1'b0);

        // New layer with pointer 0
        op_load = 1'b1;
        ptr_in  = 1'b0;
        tick();
        op_load = 1'b0;
        exp_ptr = 1'b0;
        exp_beats = 0;
        chk("ptr_relatch", intr_ptr, 0);
        chk("beat_cnt_reload", beat_cnt, 0);

        // Randomised commands
        for (int i = 0; i < 10; i++) begin
            int c;
            c = int'($urandom_range(0, DEPTH - 1));
            push_atoms(c + 1);
            run_cmd(c, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in DATA with 3 atoms still buffered
        push_atoms(5);
        cmd_pd  = {1'b1, SIZE_W'(4), 64'h6000};
        cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
        dma_rdy = 1'b1;
        tick();
        tick();
        dma_rdy = 1'b0;
        chk("mid_data_beat_cnt", beat_cnt, exp_beats + 1);
        rstn = 1'b0;
        tick();
        check_reset("mid_reset");
        rstn = 1'b1;
        atom_q.delete();
        exp_beats = 0;
        exp_ptr   = 1'b0;
        tick();
        push_atoms(3);
        run_cmd(2, 64'h7000, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
